matmul_tile_scheduler: RTL and testbench

- Sequences the systolic-array core over a tiled matrix multiply: C[M×N] = A[M×K] · B[K×N], with M and N given as tile counts of SYSTOLIC_ARRAY_DIM.
- Takes one host command and issues one core matmul command per DIM×DIM output tile, one tile outstanding at a time. After the last tile completes, returns a single response.
- Sits between the host command/response interface and the core's cmd_matmul/resp_matmul ports.

---
 rtl/matmul_sched_pkg.sv | 25 ++
 rtl/matmul_tile_addr_gen.sv | 83 ++++++++
 rtl/matmul_tile_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_matmul_tile_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_sched_pkg.sv
// Shared types and constants for the tiled matmul scheduler.
// State encoding, address/K widths and tile byte-size helpers.
package matmul_sched_pkg;

  localparam int ADDR_W       = 64;
  localparam int K_W          = 20;
  localparam int TILE_BYTES_W = 40;

  // Byte sizes for the default 8x8 array of 16-bit elements
  localparam int EB             = 16 / 8;
  localparam int OUT_TILE_BYTES = 8 * 8 * EB;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

  // Bytes in one DIM x DIM output tile for a given array edge and element width
  function automatic logic [ADDR_W-1:0] calc_out_tile_bytes(input int dim, input int dw_bits);
    calc_out_tile_bytes = ADDR_W'(dim * dim * (dw_bits / 8));
  endfunction

endpackage

// File: rtl/matmul_tile_addr_gen.sv
// Tile walker: keeps the m/n indices and the three running address pointers.
// i_init loads bases and tile geometry; i_advance steps to the next tile
// (n inner, m outer) using adders only.
module matmul_tile_addr_gen
  import matmul_sched_pkg::*;
#(
  parameter int                TILE_CNT_BITS = 16,
  parameter logic [ADDR_W-1:0] OUT_STEP      = 64'd128
) (
  input  logic                     clock,
  input  logic                     areset,
  input  logic                     i_init,
  input  logic                     i_advance,
  input  logic [TILE_CNT_BITS-1:0] i_m_tiles,
  input  logic [TILE_CNT_BITS-1:0] i_n_tiles,
  input  logic [TILE_BYTES_W-1:0]  i_tile_bytes,
  input  logic [ADDR_W-1:0]        i_act_base,
  input  logic [ADDR_W-1:0]        i_wgt_base,
  input  logic [ADDR_W-1:0]        i_out_base,
  output logic [ADDR_W-1:0]        o_act_ptr,
  output logic [ADDR_W-1:0]        o_wgt_ptr,
  output logic [ADDR_W-1:0]        o_out_ptr,
  output logic                     o_last
);

  localparam logic [TILE_CNT_BITS-1:0] CNT_ONE = {{(TILE_CNT_BITS-1){1'b0}}, 1'b1};

  logic [TILE_CNT_BITS-1:0] r_m_idx;
  logic [TILE_CNT_BITS-1:0] r_n_idx;
  logic [TILE_CNT_BITS-1:0] r_m_last;
  logic [TILE_CNT_BITS-1:0] r_n_last;
  logic [ADDR_W-1:0]        r_step;
  logic [ADDR_W-1:0]        r_wgt_base;
  logic [ADDR_W-1:0]        r_act_ptr;
  logic [ADDR_W-1:0]        r_wgt_ptr;
  logic [ADDR_W-1:0]        r_out_ptr;
  logic                     w_n_wrap;

  assign w_n_wrap  = (r_n_idx == r_n_last);
  assign o_last    = w_n_wrap && (r_m_idx == r_m_last);
  assign o_act_ptr = r_act_ptr;
  assign o_wgt_ptr = r_wgt_ptr;
  assign o_out_ptr = r_out_ptr;

  // Load job geometry on init, otherwise walk n inner / m outer on advance
  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      r_m_idx    <= '0;
      r_n_idx    <= '0;
      r_m_last   <= '0;
      r_n_last   <= '0;
      r_step     <= '0;
      r_wgt_base <= '0;
      r_act_ptr  <= '0;
      r_wgt_ptr  <= '0;
      r_out_ptr  <= '0;
    end else if (i_init) begin
      r_m_idx    <= '0;
      r_n_idx    <= '0;
      r_m_last   <= i_m_tiles - CNT_ONE;
      r_n_last   <= i_n_tiles - CNT_ONE;
      r_step     <= ADDR_W'(i_tile_bytes);
      r_wgt_base <= i_wgt_base;
      r_act_ptr  <= i_act_base;
      r_wgt_ptr  <= i_wgt_base;
      r_out_ptr  <= i_out_base;
    end else if (i_advance) begin
      r_out_ptr <= r_out_ptr + OUT_STEP;
      if (w_n_wrap) begin
        r_n_idx   <= '0;
        r_wgt_ptr <= r_wgt_base;
        r_m_idx   <= r_m_idx + CNT_ONE;
        r_act_ptr <= r_act_ptr + r_step;
      end else begin
        r_n_idx   <= r_n_idx + CNT_ONE;
        r_wgt_ptr <= r_wgt_ptr + r_step;
      end
    end else begin
      r_m_idx <= r_m_idx;
    end
  end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Tiled matmul scheduler: turns one host command into one core matmul
// command per output tile (one outstanding), then returns one response.
// Optional feature macro: MATMUL_SCHED_PERF_EN adds resp_cycles.
module matmul_tile_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_DIM = 8,
  parameter int DATA_WIDTH_BITS    = 16,
  parameter int TILE_CNT_BITS      = 16
) (
  input  logic                     clock,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [TILE_CNT_BITS-1:0] cmd_m_tiles,
  input  logic [TILE_CNT_BITS-1:0] cmd_n_tiles,
  input  logic [K_W-1:0]           cmd_inner_dimension,
  input  logic [ADDR_W-1:0]        cmd_act_addr,
  input  logic [ADDR_W-1:0]        cmd_wgt_addr,
  input  logic [ADDR_W-1:0]        cmd_out_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_tiles_done,
  output logic                     core_cmd_valid,
  input  logic                     core_cmd_ready,
  output logic [K_W-1:0]           core_cmd_inner_dimension,
  output logic [ADDR_W-1:0]        core_cmd_act_addr,
  output logic [ADDR_W-1:0]        core_cmd_wgt_addr,
  output logic [ADDR_W-1:0]        core_cmd_out_addr,
  input  logic                     core_resp_valid,
  output logic                     core_resp_ready,
  output logic                     busy
`ifdef MATMUL_SCHED_PERF_EN
  ,
  output logic [63:0]              resp_cycles
`endif
);

  localparam int                ROW_BYTES = SYSTOLIC_ARRAY_DIM * (DATA_WIDTH_BITS / 8);
  localparam logic [ADDR_W-1:0] OUT_STEP  = calc_out_tile_bytes(SYSTOLIC_ARRAY_DIM, DATA_WIDTH_BITS);

  sched_state_e            r_state;
  sched_state_e            w_state_nxt;
  logic                    w_init;
  logic                    w_advance;
  logic                    w_last;
  logic                    w_zero_job;
  logic [TILE_BYTES_W-1:0] w_tile_bytes;
  logic [K_W-1:0]          r_k;
  logic [31:0]             r_tiles_done;
  logic                    r_cmd_ready;
  logic                    r_core_cmd_valid;
  logic                    r_core_resp_ready;
  logic                    r_resp_valid;
  logic                    r_busy;

  assign w_zero_job   = (cmd_m_tiles == '0) || (cmd_n_tiles == '0) || (cmd_inner_dimension == '0);
  assign w_tile_bytes = TILE_BYTES_W'(cmd_inner_dimension) * TILE_BYTES_W'(ROW_BYTES);

  // Next-state decode plus init/advance strobes for the address walker
  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_init      = 1'b1;
          w_state_nxt = w_zero_job ? S_RESP : S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (core_cmd_ready) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (core_resp_valid) begin
          w_advance   = 1'b1;
          w_state_nxt = w_last ? S_RESP : S_ISSUE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register with handshake outputs registered from the next state
  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      r_state           <= S_IDLE;
      r_cmd_ready       <= 1'b1;
      r_core_cmd_valid  <= 1'b0;
      r_core_resp_ready <= 1'b0;
      r_resp_valid      <= 1'b0;
      r_busy            <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_cmd_ready       <= (w_state_nxt == S_IDLE);
      r_core_cmd_valid  <= (w_state_nxt == S_ISSUE);
      r_core_resp_ready <= (w_state_nxt == S_WAIT);
      r_resp_valid      <= (w_state_nxt == S_RESP);
      r_busy            <= (w_state_nxt != S_IDLE);
    end
  end

  // Latch K per job and count completed tiles
  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      r_k          <= '0;
      r_tiles_done <= '0;
    end else if (w_init) begin
      r_k          <= cmd_inner_dimension;
      r_tiles_done <= '0;
    end else if (w_advance) begin
      r_tiles_done <= r_tiles_done + 32'd1;
    end else begin
      r_tiles_done <= r_tiles_done;
    end
  end

  matmul_tile_addr_gen #(
    .TILE_CNT_BITS (TILE_CNT_BITS),
    .OUT_STEP      (OUT_STEP)
  ) u_addr_gen (
    .clock        (clock),
    .areset       (areset),
    .i_init       (w_init),
    .i_advance    (w_advance),
    .i_m_tiles    (cmd_m_tiles),
    .i_n_tiles    (cmd_n_tiles),
    .i_tile_bytes (w_tile_bytes),
    .i_act_base   (cmd_act_addr),
    .i_wgt_base   (cmd_wgt_addr),
    .i_out_base   (cmd_out_addr),
    .o_act_ptr    (core_cmd_act_addr),
    .o_wgt_ptr    (core_cmd_wgt_addr),
    .o_out_ptr    (core_cmd_out_addr),
    .o_last       (w_last)
  );

`ifdef MATMUL_SCHED_PERF_EN
  logic [63:0] r_cycles;

  // Job latency: loads 1 on fire so the first post-fire cycle is counted,
  // then runs through ISSUE/WAIT and freezes once RESP is reached
  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      r_cycles <= 64'd0;
    end else if (w_init) begin
      r_cycles <= 64'd1;
    end else if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
      r_cycles <= r_cycles + 64'd1;
    end else begin
      r_cycles <= r_cycles;
    end
  end

  assign resp_cycles = r_cycles;
`endif

  assign cmd_ready                = r_cmd_ready;
  assign core_cmd_valid           = r_core_cmd_valid;
  assign core_resp_ready          = r_core_resp_ready;
  assign resp_valid               = r_resp_valid;
  assign busy                     = r_busy;
  assign resp_tiles_done          = r_tiles_done;
  assign core_cmd_inner_dimension = r_k;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed self-checking bench for matmul_tile_scheduler (DIM=8, 16-bit).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_matmul_tile_scheduler;

  logic        clock = 1'b0;
  logic        areset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_m_tiles = 16'd0;
  logic [15:0] cmd_n_tiles = 16'd0;
  logic [19:0] cmd_inner_dimension = 20'd0;
  logic [63:0] cmd_act_addr = 64'd0;
  logic [63:0] cmd_wgt_addr = 64'd0;
  logic [63:0] cmd_out_addr = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_tiles_done;
  logic        core_cmd_valid;
  logic        core_cmd_ready = 1'b0;
  logic [19:0] core_cmd_inner_dimension;
  logic [63:0] core_cmd_act_addr;
  logic [63:0] core_cmd_wgt_addr;
  logic [63:0] core_cmd_out_addr;
  logic        core_resp_valid = 1'b0;
  logic        core_resp_ready;
  logic        busy;
`ifdef MATMUL_SCHED_PERF_EN
  logic [63:0] resp_cycles;
`endif

  int     n_checks = 0;
  int     n_pass   = 0;
  longint tb_cyc   = 0;

  matmul_tile_scheduler dut (
    .clock                    (clock),
    .areset                   (areset),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_m_tiles              (cmd_m_tiles),
    .cmd_n_tiles              (cmd_n_tiles),
    .cmd_inner_dimension      (cmd_inner_dimension),
    .cmd_act_addr             (cmd_act_addr),
    .cmd_wgt_addr             (cmd_wgt_addr),
    .cmd_out_addr             (cmd_out_addr),
    .resp_valid               (resp_valid),
    .resp_ready               (resp_ready),
    .resp_tiles_done          (resp_tiles_done),
    .core_cmd_valid           (core_cmd_valid),
    .core_cmd_ready           (core_cmd_ready),
    .core_cmd_inner_dimension (core_cmd_inner_dimension),
    .core_cmd_act_addr        (core_cmd_act_addr),
    .core_cmd_wgt_addr        (core_cmd_wgt_addr),
    .core_cmd_out_addr        (core_cmd_out_addr),
    .core_resp_valid          (core_resp_valid),
    .core_resp_ready          (core_resp_ready),
    .busy                     (busy)
`ifdef MATMUL_SCHED_PERF_EN
    ,
    .resp_cycles              (resp_cycles)
`endif
  );

  // 100 MHz clock
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
    tb_cyc++;
  endtask

  // Runs one job acting as host and core. Expected tile addresses come from
  // the closed-form act=A+m*K*16, wgt=B+n*K*16, out=C+(m*N+n)*128.
  task automatic do_job(input string tag, input int m, input int n, input logic [19:0] k,
                        input logic [63:0] a, input logic [63:0] w, input logic [63:0] o,
                        input int cstall, input int rdelay, input int rstall,
                        input int abort_tile, output longint meas);
    int total;
    int mi;
    int ni;
    logic [63:0] ea;
    logic [63:0] ew;
    logic [63:0] eo;
    total = (m == 0 || n == 0 || k == 20'd0) ? 0 : m * n;
    meas = 0;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL %s idle_cmd_ready got=%b want=1", tag, cmd_ready);
    else n_pass++;
    cmd_valid = 1'b1;
    cmd_m_tiles = 16'(m);
    cmd_n_tiles = 16'(n);
    cmd_inner_dimension = k;
    cmd_act_addr = a;
    cmd_wgt_addr = w;
    cmd_out_addr = o;
    tb_cyc = 0;
    tick();
    cmd_valid = 1'b0;
    for (int t = 0; t < total; t++) begin
      mi = t / n;
      ni = t % n;
      ea = a + 64'(mi) * 64'(k) * 64'd16;
      ew = w + 64'(ni) * 64'(k) * 64'd16;
      eo = o + 64'(t) * 64'd128;
      for (int s = 0; s <= cstall; s++) begin
        n_checks++;
        if (core_cmd_valid !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1 || resp_valid !== 1'b0)
          $display("FAIL %s tile%0d ctl cval=%b crdy=%b busy=%b rval=%b want 1/0/1/0",
                   tag, t, core_cmd_valid, cmd_ready, busy, resp_valid);
        else n_pass++;
        n_checks++;
        if (core_cmd_act_addr !== ea || core_cmd_wgt_addr !== ew || core_cmd_out_addr !== eo ||
            core_cmd_inner_dimension !== k)
          $display("FAIL %s tile%0d addr act=%h wgt=%h out=%h k=%0d want %h %h %h %0d",
                   tag, t, core_cmd_act_addr, core_cmd_wgt_addr, core_cmd_out_addr,
                   core_cmd_inner_dimension, ea, ew, eo, k);
        else n_pass++;
        if (s < cstall) begin
          core_resp_valid = 1'b1;
          n_checks++;
          if (core_resp_ready !== 1'b0) $display("FAIL %s issue_resp_ready got=%b want=0", tag, core_resp_ready);
          else n_pass++;
        end else begin
          core_resp_valid = 1'b0;
          core_cmd_ready = 1'b1;
        end
        tick();
      end
      core_cmd_ready = 1'b0;
      core_resp_valid = 1'b0;
      n_checks++;
      if (core_cmd_valid !== 1'b0 || core_resp_ready !== 1'b1)
        $display("FAIL %s tile%0d wait cval=%b rrdy=%b want 0/1", tag, t, core_cmd_valid, core_resp_ready);
      else n_pass++;
      if (t == abort_tile) begin
        areset = 1'b0;
        #1;
        n_checks++;
        if (core_cmd_valid !== 1'b0 || busy !== 1'b0 || core_resp_ready !== 1'b0 || resp_valid !== 1'b0)
          $display("FAIL %s abort cval=%b busy=%b rrdy=%b rval=%b want 0/0/0/0",
                   tag, core_cmd_valid, busy, core_resp_ready, resp_valid);
        else n_pass++;
        tick();
        areset = 1'b1;
        return;
      end
      repeat (rdelay) tick();
      core_resp_valid = 1'b1;
      tick();
      core_resp_valid = 1'b0;
    end
    meas = tb_cyc;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_tiles_done !== 32'(total) || core_cmd_valid !== 1'b0 || cmd_ready !== 1'b0)
      $display("FAIL %s resp rval=%b done=%0d cval=%b crdy=%b want 1/%0d/0/0",
               tag, resp_valid, resp_tiles_done, core_cmd_valid, cmd_ready, total);
    else n_pass++;
`ifdef MATMUL_SCHED_PERF_EN
    n_checks++;
    if (resp_cycles !== 64'(meas)) $display("FAIL %s resp_cycles got=%0d want=%0d", tag, resp_cycles, meas);
    else n_pass++;
`endif
    for (int s = 0; s < rstall; s++) begin
      cmd_valid = 1'b1;
      tick();
      n_checks++;
      if (resp_valid !== 1'b1 || resp_tiles_done !== 32'(total) || cmd_ready !== 1'b0 || core_cmd_valid !== 1'b0)
        $display("FAIL %s resp_hold rval=%b done=%0d crdy=%b cval=%b want 1/%0d/0/0",
                 tag, resp_valid, resp_tiles_done, cmd_ready, core_cmd_valid, total);
      else n_pass++;
    end
    cmd_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s post_resp rval=%b crdy=%b busy=%b want 0/1/0", tag, resp_valid, cmd_ready, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    areset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (cmd_ready !== 1'b1 || core_cmd_valid !== 1'b0 || resp_valid !== 1'b0 ||
        core_resp_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_ctl crdy=%b cval=%b rval=%b rrdy=%b busy=%b want 1/0/0/0/0",
               cmd_ready, core_cmd_valid, resp_valid, core_resp_ready, busy);
    else n_pass++;
    n_checks++;
    if (resp_tiles_done !== 32'd0 || core_cmd_act_addr !== 64'd0 || core_cmd_wgt_addr !== 64'd0 ||
        core_cmd_out_addr !== 64'd0 || core_cmd_inner_dimension !== 20'd0)
      $display("FAIL reset_data done=%0d act=%h wgt=%h out=%h k=%0d want all 0",
               resp_tiles_done, core_cmd_act_addr, core_cmd_wgt_addr, core_cmd_out_addr,
               core_cmd_inner_dimension);
    else n_pass++;
`ifdef MATMUL_SCHED_PERF_EN
    n_checks++;
    if (resp_cycles !== 64'd0) $display("FAIL reset_resp_cycles got=%0d want=0", resp_cycles);
    else n_pass++;
`endif
    areset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single();
    longint meas;
    do_job("single", 1, 1, 20'd32, 64'h1000, 64'h2000, 64'h3000, 0, 0, 0, -1, meas);
  endtask

  task automatic test_multi();
    longint meas;
    do_job("multi", 2, 3, 20'd32, 64'h1000, 64'h2000, 64'h3000, 0, 2, 1, -1, meas);
  endtask

  task automatic test_zero();
    longint meas;
    do_job("zero_m", 0, 3, 20'd32, 64'h1000, 64'h2000, 64'h3000, 0, 0, 1, -1, meas);
    do_job("zero_k", 1, 1, 20'd0, 64'h1000, 64'h2000, 64'h3000, 0, 0, 0, -1, meas);
    do_job("zero_n", 2, 0, 20'd8, 64'h1000, 64'h2000, 64'h3000, 0, 0, 0, -1, meas);
  endtask

  task automatic test_stall();
    longint meas;
    do_job("stall", 2, 2, 20'd8, 64'h4000, 64'h8000, 64'hC000, 5, 20, 4, -1, meas);
  endtask

  task automatic test_abort();
    longint meas;
    do_job("abort", 2, 3, 20'd32, 64'h1000, 64'h2000, 64'h3000, 0, 0, 0, 2, meas);
`ifdef MATMUL_SCHED_PERF_EN
    n_checks++;
    if (resp_cycles !== 64'd0) $display("FAIL abort_resp_cycles got=%0d want=0", resp_cycles);
    else n_pass++;
`endif
    do_job("after_abort", 1, 1, 20'd16, 64'h5000, 64'h6000, 64'h7000, 0, 1, 0, -1, meas);
  endtask

  task automatic test_back_to_back();
    longint meas;
    do_job("b2b_wrap", 1, 2, 20'd4, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFC0,
           64'hFFFF_FFFF_FFFF_FFC0, 0, 0, 0, -1, meas);
    do_job("b2b_next", 3, 1, 20'd1, 64'h0, 64'h100, 64'h200, 1, 0, 0, -1, meas);
  endtask

`ifdef MATMUL_SCHED_PERF_EN
  task automatic test_perf();
    longint meas;
    do_job("perf", 1, 2, 20'd32, 64'h1000, 64'h2000, 64'h3000, 0, 9, 2, -1, meas);
    n_checks++;
    if (resp_cycles !== 64'd23) $display("FAIL perf_hand resp_cycles got=%0d want=23", resp_cycles);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_stall();
    test_abort();
    test_back_to_back();
`ifdef MATMUL_SCHED_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
